// File: rtl/mux_select_register_bank.sv
// Registered mux bank: 1-bit and 8-bit 2:1 paths plus a 16-bit 16:1 result select,
// each built from the shared combinational mux primitives and captured on enable.

module mux_2 (
    input  logic selector,
    input  logic i0,
    input  logic i1,
    output logic out
);
    assign out = selector ? i1 : i0;
endmodule

module mux_2_eight_bits (
    input  logic       selector,
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    output logic [7:0] out
);
    for (genvar b = 0; b < 8; b++) begin : g_bit
        mux_2 u_mux (.selector(selector), .i0(i0[b]), .i1(i1[b]), .out(out[b]));
    end
endmodule

module mux_2_sixteen_bits (
    input  logic        selector,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    output logic [15:0] out
);
    mux_2_eight_bits u_hi (.selector(selector), .i0(i0[15:8]), .i1(i1[15:8]), .out(out[15:8]));
    mux_2_eight_bits u_lo (.selector(selector), .i0(i0[7:0]),  .i1(i1[7:0]),  .out(out[7:0]));
endmodule

module mux_4_sixteen_bits (
    input  logic [1:0]  selectors,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    input  logic [15:0] i2,
    input  logic [15:0] i3,
    output logic [15:0] out
);
    logic [15:0] lo;
    logic [15:0] hi;

    mux_2_sixteen_bits u_lo  (.selector(selectors[0]), .i0(i0), .i1(i1), .out(lo));
    mux_2_sixteen_bits u_hi  (.selector(selectors[0]), .i0(i2), .i1(i3), .out(hi));
    mux_2_sixteen_bits u_fin (.selector(selectors[1]), .i0(lo), .i1(hi), .out(out));
endmodule

module mux_8_sixteen_bits (
    input  logic [2:0]  selectors,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    input  logic [15:0] i2,
    input  logic [15:0] i3,
    input  logic [15:0] i4,
    input  logic [15:0] i5,
    input  logic [15:0] i6,
    input  logic [15:0] i7,
    output logic [15:0] out
);
    logic [15:0] lo;
    logic [15:0] hi;

    mux_4_sixteen_bits u_lo (.selectors(selectors[1:0]), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .out(lo));
    mux_4_sixteen_bits u_hi (.selectors(selectors[1:0]), .i0(i4), .i1(i5), .i2(i6), .i3(i7), .out(hi));
    mux_2_sixteen_bits u_fin (.selector(selectors[2]), .i0(lo), .i1(hi), .out(out));
endmodule

module mux_16_sixteen_bits (
    input  logic [3:0]  selectors,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    input  logic [15:0] i2,
    input  logic [15:0] i3,
    input  logic [15:0] i4,
    input  logic [15:0] i5,
    input  logic [15:0] i6,
    input  logic [15:0] i7,
    input  logic [15:0] i8,
    input  logic [15:0] i9,
    input  logic [15:0] i10,
    input  logic [15:0] i11,
    input  logic [15:0] i12,
    input  logic [15:0] i13,
    input  logic [15:0] i14,
    input  logic [15:0] i15,
    output logic [15:0] out
);
    logic [15:0] lo;
    logic [15:0] hi;

    mux_8_sixteen_bits u_lo (.selectors(selectors[2:0]), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
                             .i4(i4), .i5(i5), .i6(i6), .i7(i7), .out(lo));
    mux_8_sixteen_bits u_hi (.selectors(selectors[2:0]), .i0(i8), .i1(i9), .i2(i10), .i3(i11),
                             .i4(i12), .i5(i13), .i6(i14), .i7(i15), .out(hi));
    mux_2_sixteen_bits u_fin (.selector(selectors[3]), .i0(lo), .i1(hi), .out(out));
endmodule

module mux_select_register_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        selector,
    input  logic        i0_1,
    input  logic        i1_1,
    input  logic [7:0]  i0_8,
    input  logic [7:0]  i1_8,
    input  logic [15:0] i0_16,
    input  logic [15:0] i1_16,
    input  logic [15:0] i2_16,
    input  logic [15:0] i3_16,
    input  logic [15:0] i4_16,
    input  logic [15:0] i5_16,
    input  logic [15:0] i6_16,
    input  logic [15:0] i7_16,
    input  logic [15:0] i8_16,
    input  logic [15:0] i9_16,
    input  logic [15:0] i10_16,
    input  logic [15:0] i11_16,
    input  logic [15:0] i12_16,
    input  logic [15:0] i13_16,
    input  logic [15:0] i14_16,
    input  logic [15:0] i15_16,
    input  logic [3:0]  selectors,
    output logic        out_1,
    output logic [7:0]  out_8,
    output logic [15:0] out_16
);
    logic        out_1_d,  out_1_q;
    logic [7:0]  out_8_d,  out_8_q;
    logic [15:0] out_16_d, out_16_q;

    mux_2 u_mux_1 (.selector(selector), .i0(i0_1), .i1(i1_1), .out(out_1_d));

    mux_2_eight_bits u_mux_8 (.selector(selector), .i0(i0_8), .i1(i1_8), .out(out_8_d));

    mux_16_sixteen_bits u_mux_16 (
        .selectors(selectors),
        .i0(i0_16),   .i1(i1_16),   .i2(i2_16),   .i3(i3_16),
        .i4(i4_16),   .i5(i5_16),   .i6(i6_16),   .i7(i7_16),
        .i8(i8_16),   .i9(i9_16),   .i10(i10_16), .i11(i11_16),
        .i12(i12_16), .i13(i13_16), .i14(i14_16), .i15(i15_16),
        .out(out_16_d)
    );

    // Reset wins over enable; all three paths load together.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_1_q  <= 1'b0;
            out_8_q  <= 8'h00;
            out_16_q <= 16'h0000;
        end else if (en) begin
            out_1_q  <= out_1_d;
            out_8_q  <= out_8_d;
            out_16_q <= out_16_d;
        end
    end

    assign out_1  = out_1_q;
    assign out_8  = out_8_q;
    assign out_16 = out_16_q;
endmodule

// File: tb/tb_mux_select_register_bank.sv
// Scoreboard bench for mux_select_register_bank: expected register contents are queued
// when each cycle's stimulus is applied and compared after the capturing edge.

module tb_mux_select_register_bank;
    logic        clk = 1'b0;
    logic        reset, en, selector, i0_1, i1_1;
    logic [7:0]  i0_8, i1_8;
    logic [15:0] in16 [16];
    logic [3:0]  selectors;
    logic        out_1;
    logic [7:0]  out_8;
    logic [15:0] out_16;

    typedef struct {
        string       tag;
        logic        o1;
        logic [7:0]  o8;
        logic [15:0] o16;
    } exp_t;

    exp_t        sb [$];
    logic        m_1;
    logic [7:0]  m_8;
    logic [15:0] m_16;
    int          checks = 0;
    int          errors = 0;

    localparam logic [15:0] PAT [16] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000,
                                         16'hF0F0, 16'h0F0F, 16'hAAAA, 16'h5555,
                                         16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                         16'h1357, 16'h2468, 16'hACE0, 16'hFACE};

    mux_select_register_bank dut (
        .clk(clk), .reset(reset), .en(en), .selector(selector),
        .i0_1(i0_1), .i1_1(i1_1), .i0_8(i0_8), .i1_8(i1_8),
        .i0_16(in16[0]),   .i1_16(in16[1]),   .i2_16(in16[2]),   .i3_16(in16[3]),
        .i4_16(in16[4]),   .i5_16(in16[5]),   .i6_16(in16[6]),   .i7_16(in16[7]),
        .i8_16(in16[8]),   .i9_16(in16[9]),   .i10_16(in16[10]), .i11_16(in16[11]),
        .i12_16(in16[12]), .i13_16(in16[13]), .i14_16(in16[14]), .i15_16(in16[15]),
        .selectors(selectors),
        .out_1(out_1), .out_8(out_8), .out_16(out_16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model the register update for the inputs now applied, queue it, then compare after the edge.
    task automatic cycle(input string tag);
        exp_t e;
        if (reset) begin
            m_1 = 1'b0; m_8 = 8'h00; m_16 = 16'h0000;
        end else if (en) begin
            m_1  = selector ? i1_1 : i0_1;
            m_8  = selector ? i1_8 : i0_8;
            m_16 = in16[selectors];
        end
        sb.push_back('{tag, m_1, m_8, m_16});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".out_1"},  16'(out_1),  16'(e.o1));
        check({e.tag, ".out_8"},  16'(out_8),  16'(e.o8));
        check({e.tag, ".out_16"}, out_16,      e.o16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] tt [4];
        tt = '{3'b000, 3'b100, 3'b011, 3'b101};

        reset = 1'b1; en = 1'b1; selector = 1'b1; i0_1 = 1'b1; i1_1 = 1'b1;
        i0_8 = 8'hA5; i1_8 = 8'h5A; selectors = 4'd7;
        for (int k = 0; k < 16; k++) in16[k] = 16'hFFFF - 16'(k);
        #1;
        cycle("reset0");
        cycle("reset1");

        reset = 1'b0;
        for (int k = 0; k < 16; k++) in16[k] = PAT[k];
        for (int k = 0; k < 4; k++) begin
            {i0_1, i1_1, selector} = tt[k];
            cycle($sformatf("tt%0d", k));
        end

        i0_8 = 8'hAA; i1_8 = 8'h55;
        selector = 1'b0; cycle("p8_sel0");
        selector = 1'b1; cycle("p8_sel1");

        for (int s = 0; s < 16; s++) begin
            selectors = 4'(s);
            cycle($sformatf("sweep%0d", s));
        end

        selectors = 4'd15; cycle("hold_load");
        en = 1'b0; selectors = 4'd0; i0_1 = 1'b1; selector = 1'b0; i0_8 = 8'h3C;
        for (int k = 0; k < 3; k++) cycle($sformatf("hold%0d", k));
        en = 1'b1; cycle("hold_release");

        selectors = 4'd11; cycle("mid_load");
        reset = 1'b1; cycle("mid_reset");
        reset = 1'b0; cycle("mid_reload");

        for (int k = 0; k < 24; k++) begin
            en = 1'($urandom_range(0, 3) != 0);
            reset = 1'($urandom_range(0, 7) == 0);
            selector = 1'($urandom);
            i0_1 = 1'($urandom); i1_1 = 1'($urandom);
            i0_8 = 8'($urandom); i1_8 = 8'($urandom);
            selectors = 4'($urandom);
            for (int j = 0; j < 16; j++) in16[j] = 16'($urandom);
            cycle($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
